// File: rtl/demux_striping.sv
// demux_striping: round-robin word distributor onto two half-rate lanes
// A burst always starts on lane 0; a burst ending on lane 0 pads lane 1 so lanes stay paired.
module demux_striping #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] PAD_WORD = '0,
  parameter int                CNT_W    = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic              odd_burst,
  output logic [CNT_W-1:0]  words_striped
);
  typedef enum logic [1:0] {IDLE, L1, L0} state_t;
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_lane_0, r_lane_1;
  logic              r_valid_0, r_valid_1, r_odd;
  logic [CNT_W-1:0]  r_cnt;
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Any gap realigns to IDLE so the next burst opens on lane 0
  always_comb begin
    w_next = IDLE;
    if (valid_in) w_next = (r_state == L1) ? L0 : L1;
  end
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_lane_0  <= '0;
      r_lane_1  <= '0;
      r_valid_0 <= 1'b0;
      r_valid_1 <= 1'b0;
      r_odd     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_odd <= (r_state == L1) && !valid_in;
      if (valid_in && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      if (valid_in && r_state == L1) begin
        r_lane_1  <= data_in;
        r_valid_1 <= 1'b1;
      end else if (valid_in) begin
        r_lane_0  <= data_in;
        r_valid_0 <= 1'b1;
      end else if (r_state == L1) begin
        r_lane_1  <= PAD_WORD;
        r_valid_1 <= 1'b0;
      end else begin
        r_valid_0 <= 1'b0;
        r_valid_1 <= 1'b0;
      end
    end
  end
  assign lane_0        = r_lane_0;
  assign lane_1        = r_lane_1;
  assign valid_0       = r_valid_0;
  assign valid_1       = r_valid_1;
  assign odd_burst     = r_odd;
  assign words_striped = r_cnt;
endmodule

// File: tb/tb_demux_striping.sv
// tb_demux_striping: scoreboard bench for demux_striping
// Expected lane states are queued with each stimulus word and popped one cycle later.
module tb_demux_striping;
  localparam logic [31:0] PAD = 32'h5A5A5A5A;
  typedef struct packed {logic [74:0] v; logic [74:0] m;} exp_t;
  typedef struct packed {logic v; logic [31:0] d;} stim_t;
  logic        clk_2f = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        valid_6 = 1'b0;
  logic [31:0] lane_0, lane_1, lane_0_6, lane_1_6;
  logic        valid_0, valid_1, odd_burst, valid_0_6, valid_1_6, odd_burst_6;
  logic [7:0]  words_striped;
  logic [1:0]  words_striped_6;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        q[$];
  stim_t       sq[$];
  logic [1:0]  q6[$];
  demux_striping #(.DATA_W(32), .PAD_WORD(PAD), .CNT_W(8)) u_dut (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_0(lane_0), .lane_1(lane_1), .valid_0(valid_0), .valid_1(valid_1),
    .odd_burst(odd_burst), .words_striped(words_striped)
  );
  demux_striping #(.DATA_W(32), .PAD_WORD(PAD), .CNT_W(2)) u_dut6 (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_6),
    .lane_0(lane_0_6), .lane_1(lane_1_6), .valid_0(valid_0_6), .valid_1(valid_1_6),
    .odd_burst(odd_burst_6), .words_striped(words_striped_6)
  );
  always #5 clk_2f = ~clk_2f;
  function automatic logic [74:0] obs();
    return {lane_0, lane_1, valid_0, valid_1, odd_burst, words_striped};
  endfunction
  // care_v0=0 leaves valid_0 unchecked on the pad cycle, where it is not pinned down
  function automatic exp_t mk(input logic [31:0] l0, input logic [31:0] l1, input logic v0,
                              input logic v1, input logic o, input logic [7:0] c, input logic care_v0);
    exp_t e;
    e.v = {l0, l1, v0, v1, o, c};
    e.m = '1;
    e.m[10] = care_v0;
    return e;
  endfunction
  task automatic send(input logic v, input logic [31:0] d, input exp_t e);
    sq.push_back('{v: v, d: d});
    q.push_back(e);
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk_2f);
    #1;
    n_chk++;
    if (obs() !== '0) begin n_fail++; $display("FAIL reset_held: got %h expected 0", obs()); end
    reset = 1'b1;
    valid_in = 1'b0;
    @(posedge clk_2f);
    #1;
    n_chk++;
    if (obs() !== '0) begin n_fail++; $display("FAIL reset_release: got %h expected 0", obs()); end
  endtask
  task automatic test_even_burst();
    stim_t s;
    exp_t  e;
    send(1, 32'hAAAAAAAA, mk(32'hAAAAAAAA, 32'h0, 1, 0, 0, 8'd1, 1));
    send(1, 32'hEEEEEEEE, mk(32'hAAAAAAAA, 32'hEEEEEEEE, 1, 1, 0, 8'd2, 1));
    send(1, 32'hCCCCCCCC, mk(32'hCCCCCCCC, 32'hEEEEEEEE, 1, 1, 0, 8'd3, 1));
    send(1, 32'hAAAAAAAA, mk(32'hCCCCCCCC, 32'hAAAAAAAA, 1, 1, 0, 8'd4, 1));
    send(0, 32'h0, mk(32'hCCCCCCCC, 32'hAAAAAAAA, 0, 0, 0, 8'd4, 1));
    send(0, 32'h0, mk(32'hCCCCCCCC, 32'hAAAAAAAA, 0, 0, 0, 8'd4, 1));
    while (sq.size() > 0) begin
      s = sq.pop_front(); valid_in = s.v; data_in = s.d;
      @(posedge clk_2f); #1;
      e = q.pop_front(); n_chk++;
      if (((obs() ^ e.v) & e.m) !== '0) begin n_fail++; $display("FAIL even_burst: got %h expected %h mask %h", obs(), e.v, e.m); end
    end
  endtask
  task automatic test_odd_burst();
    stim_t s;
    exp_t  e;
    send(1, 32'h11111111, mk(32'h11111111, 32'hAAAAAAAA, 1, 0, 0, 8'd5, 1));
    send(1, 32'h99999999, mk(32'h11111111, 32'h99999999, 1, 1, 0, 8'd6, 1));
    send(1, 32'h12345678, mk(32'h12345678, 32'h99999999, 1, 1, 0, 8'd7, 1));
    send(0, 32'h0, mk(32'h12345678, PAD, 0, 0, 1, 8'd7, 0));
    send(0, 32'h0, mk(32'h12345678, PAD, 0, 0, 0, 8'd7, 1));
    while (sq.size() > 0) begin
      s = sq.pop_front(); valid_in = s.v; data_in = s.d;
      @(posedge clk_2f); #1;
      e = q.pop_front(); n_chk++;
      if (((obs() ^ e.v) & e.m) !== '0) begin n_fail++; $display("FAIL odd_burst: got %h expected %h mask %h", obs(), e.v, e.m); end
    end
  endtask
  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    send(1, 32'hD0000001, mk(32'hD0000001, PAD, 1, 0, 0, 8'd8, 1));
    send(1, 32'hD0000002, mk(32'hD0000001, 32'hD0000002, 1, 1, 0, 8'd9, 1));
    send(1, 32'hD0000003, mk(32'hD0000003, 32'hD0000002, 1, 1, 0, 8'd10, 1));
    send(0, 32'hFFFFFFFF, mk(32'hD0000003, PAD, 0, 0, 1, 8'd10, 0));
    send(1, 32'hB0000001, mk(32'hB0000001, PAD, 1, 0, 0, 8'd11, 1));
    send(1, 32'hB0000002, mk(32'hB0000001, 32'hB0000002, 1, 1, 0, 8'd12, 1));
    send(0, 32'h0, mk(32'hB0000001, 32'hB0000002, 0, 0, 0, 8'd12, 1));
    while (sq.size() > 0) begin
      s = sq.pop_front(); valid_in = s.v; data_in = s.d;
      @(posedge clk_2f); #1;
      e = q.pop_front(); n_chk++;
      if (((obs() ^ e.v) & e.m) !== '0) begin n_fail++; $display("FAIL back_to_back: got %h expected %h mask %h", obs(), e.v, e.m); end
    end
  endtask
  task automatic test_async_reset();
    stim_t s;
    exp_t  e;
    send(1, 32'hE0000001, mk(32'hE0000001, 32'hB0000002, 1, 0, 0, 8'd13, 1));
    send(1, 32'hE0000002, mk(32'hE0000001, 32'hE0000002, 1, 1, 0, 8'd14, 1));
    send(1, 32'hE0000003, mk(32'hE0000003, 32'hE0000002, 1, 1, 0, 8'd15, 1));
    while (sq.size() > 0) begin
      s = sq.pop_front(); valid_in = s.v; data_in = s.d;
      @(posedge clk_2f); #1;
      e = q.pop_front(); n_chk++;
      if (((obs() ^ e.v) & e.m) !== '0) begin n_fail++; $display("FAIL pre_reset: got %h expected %h mask %h", obs(), e.v, e.m); end
    end
    valid_in = 1'b0;
    #3 reset = 1'b0;
    #1;
    n_chk++;
    if (obs() !== '0) begin n_fail++; $display("FAIL async_clear: got %h expected 0", obs()); end
    @(posedge clk_2f); #1;
    n_chk++;
    if (obs() !== '0) begin n_fail++; $display("FAIL no_pad_in_reset: got %h expected 0", obs()); end
    reset = 1'b1;
    send(0, 32'h0, mk(32'h0, 32'h0, 0, 0, 0, 8'd0, 1));
    send(1, 32'hF0000001, mk(32'hF0000001, 32'h0, 1, 0, 0, 8'd1, 1));
    send(0, 32'h0, mk(32'hF0000001, PAD, 0, 0, 1, 8'd1, 0));
    while (sq.size() > 0) begin
      s = sq.pop_front(); valid_in = s.v; data_in = s.d;
      @(posedge clk_2f); #1;
      e = q.pop_front(); n_chk++;
      if (((obs() ^ e.v) & e.m) !== '0) begin n_fail++; $display("FAIL post_reset: got %h expected %h mask %h", obs(), e.v, e.m); end
    end
  endtask
  task automatic test_saturate();
    logic [1:0] c;
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q6.push_back(i < 3 ? 2'(i + 1) : 2'd3);
      valid_6 = 1'b1; data_in = 32'h60000000 + 32'(i);
      @(posedge clk_2f); #1;
      c = q6.pop_front(); n_chk++;
      if (words_striped_6 !== c) begin n_fail++; $display("FAIL saturate[%0d]: got %0d expected %0d", i, words_striped_6, c); end
    end
    valid_6 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_even_burst();
    test_odd_burst();
    test_back_to_back();
    test_async_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
